// File: rtl/keypad_scan_pkg.sv
// Shared types for the keypad scanner: debounce states, matrix width and
// the frame decoder that turns 16 row samples into a single-key verdict.
package keypad_scan_pkg;

  localparam int KP_W    = 4;
  localparam int FRAME_W = KP_W * KP_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } kstate_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } frame_res_t;

  // Bit index c*4+r of the frame is the key code {col, row}; a hit needs
  // exactly one low bit so ghosting and multi-press are rejected.
  function automatic frame_res_t frame_decode(input logic [FRAME_W-1:0] frame);
    frame_res_t r;
    logic [4:0] n;
    r = '0;
    n = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (!frame[i]) begin
        n      = n + 5'd1;
        r.code = 4'(i);
      end
    end
    r.hit = (n == 5'd1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave the board/consumer side.
interface keypad_scan_if;
  import keypad_scan_pkg::*;

  logic [KP_W-1:0] row_in;
  logic [KP_W-1:0] col_out;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_held;

  modport master (input row_in, output col_out, output key_code,
                  output key_valid, output key_held);
  modport slave  (output row_in, input col_out, input key_code,
                  input key_valid, input key_held);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer, parameterized width and reset value.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column walk with prescaler, per-frame single-key
// detection and a press/release debounce FSM.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] DB_L = SW'(DEBOUNCE);

  logic [KP_W-1:0] row_s;

  sync2 #(.W(KP_W), .RST_VAL({KP_W{1'b1}})) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (kp.row_in),
    .q   (row_s)
  );

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]      col_q, col_d;
  logic [KP_W-1:0] col_out_q, col_out_d;
  logic [11:0]     frame_q, frame_d;
  kstate_t         state_q, state_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;

  logic          tc, frame_end, match_cand, match_held;
  logic [SW-1:0] stab_inc, stab_nx;
  frame_res_t    fd;

  always_comb begin
    tc        = (div_cnt_q == DW'(SCAN_DIV - 1));
    frame_end = tc && (col_q == 2'd3);
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    col_d     = tc ? col_q + 2'd1 : col_q;
    col_out_d = tc ? ~(4'b0001 << col_d) : col_out_q;

    frame_d = frame_q;
    if (tc && col_q != 2'd3) frame_d[{col_q, 2'b00} +: 4] = row_s;
    // Column 3 is folded in straight from row_s on the evaluating edge.
    fd = frame_decode({row_s, frame_q});

    match_cand = fd.hit && (fd.code == cand_q);
    match_held = fd.hit && (fd.code == code_q);
    stab_inc   = stab_q + 1'b1;
    stab_nx    = '0;

    state_d = state_q;
    stab_d  = stab_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;

    if (frame_end) begin
      unique case (state_q)
        IDLE, PRESS_DB: begin
          if (state_q == PRESS_DB && match_cand) stab_nx = stab_inc;
          else if (fd.hit)                       stab_nx = SW'(1);
          if (fd.hit) cand_d = fd.code;
          if (stab_nx == DB_L) begin
            state_d = PRESSED;
            stab_d  = '0;
            code_d  = fd.code;
            valid_d = 1'b1;
          end else if (stab_nx != '0) begin
            state_d = PRESS_DB;
            stab_d  = stab_nx;
          end else begin
            state_d = IDLE;
            stab_d  = '0;
          end
        end
        PRESSED, REL_DB: begin
          if (!match_held) stab_nx = (state_q == REL_DB) ? stab_inc : SW'(1);
          if (stab_nx == DB_L) begin
            state_d = IDLE;
            stab_d  = '0;
          end else if (stab_nx != '0) begin
            state_d = REL_DB;
            stab_d  = stab_nx;
          end else begin
            state_d = PRESSED;
            stab_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      col_q     <= '0;
      col_out_q <= 4'b1110;
      frame_q   <= '0;
      state_q   <= IDLE;
      stab_q    <= '0;
      cand_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
      stab_q    <= stab_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign kp.col_out   = col_out_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = (state_q == PRESSED) || (state_q == REL_DB);
endmodule
